// File: rtl/myo_spi_responder.sv
// -----------------------------------------------------------------------------
// myo_spi_responder
//
// SPI mode-0 slave that stands in for a motor board at the far end of the
// myocontrol SPI master link, so the master can be exercised in loop-back
// without hardware. The SPI pins are asynchronous and are oversampled in the
// system clock domain; the system clock must run at least 8x SCK.
//
// A frame is nominally FRAME_WORDS words of WORD_BITS bits, MSB first. Each
// completed received word is reported on a one-cycle strobe interface. The
// response words are taken from tx_data, which is captured into a shadow
// register when the frame starts, so later changes to tx_data do not disturb
// the frame in flight.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high reset
//   sck, mosi      SPI clock / data from the master (asynchronous)
//   ss_n           slave select, active low (asynchronous)
//   miso           SPI data to the master
//   miso_en        high while selected (drives the top-level tristate)
//   tx_data        response words, word k at [(k+1)*WORD_BITS-1 : k*WORD_BITS]
//   rx_word        last completed received word (held between strobes)
//   rx_word_valid  one-cycle strobe qualifying rx_word / rx_word_index
//   rx_word_index  position of rx_word in the frame, saturating at FRAME_WORDS
//   frame_active   high while a frame is in progress
//   frame_done     one-cycle strobe at frame end
//   frame_error    frame status, valid with frame_done, held until the next one
//   words_received complete words in the last frame, saturating at FRAME_WORDS+1
// -----------------------------------------------------------------------------
module myo_spi_responder #(
    parameter int WORD_BITS   = 16,
    parameter int FRAME_WORDS = 4,
    parameter int IDX_BITS    = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             sck,
    input  logic                             mosi,
    input  logic                             ss_n,
    output logic                             miso,
    output logic                             miso_en,
    input  logic [WORD_BITS*FRAME_WORDS-1:0] tx_data,
    output logic [WORD_BITS-1:0]             rx_word,
    output logic                             rx_word_valid,
    output logic [IDX_BITS-1:0]              rx_word_index,
    output logic                             frame_active,
    output logic                             frame_done,
    output logic                             frame_error,
    output logic [IDX_BITS-1:0]              words_received
);

    localparam int                 BIT_W    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(WORD_BITS - 1);
    localparam logic [IDX_BITS-1:0] FULL_IDX = IDX_BITS'(FRAME_WORDS);
    localparam logic [IDX_BITS-1:0] SAT_IDX  = IDX_BITS'(FRAME_WORDS + 1);

    // ST_CLOSING covers the case where the slave select rises while a just
    // completed word is still waiting to be strobed: the word strobe goes out
    // first and frame_done follows one cycle later.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_CLOSING = 2'd2
    } state_t;

    // Select word idx of the shadowed response vector.
    function automatic logic [WORD_BITS-1:0] shadow_word(
        input logic [WORD_BITS*FRAME_WORDS-1:0] vec,
        input logic [IDX_BITS-1:0]              idx
    );
        logic [WORD_BITS-1:0] w;
        w = '0;
        for (int k = 0; k < FRAME_WORDS; k++) begin
            w = (idx == IDX_BITS'(k)) ? vec[k*WORD_BITS +: WORD_BITS] : w;
        end
        return w;
    endfunction

    // Synchroniser chains: meta -> sync, plus a prev copy for edge detection.
    logic sck_meta_r, sck_sync_r, sck_prev_r;
    logic mosi_meta_r, mosi_sync_r;
    logic ss_meta_r, ss_sync_r, ss_prev_r;
    logic [1:0] sync_fill_r;
    logic armed_r;

    state_t state_r, next_state_s;

    logic [WORD_BITS*FRAME_WORDS-1:0] shadow_r;
    logic [WORD_BITS-1:0]             tx_shift_r;
    logic [WORD_BITS-1:0]             rx_shift_r;
    logic [BIT_W-1:0]                 bit_cnt_r;
    logic [IDX_BITS-1:0]              word_idx_r;
    logic [IDX_BITS-1:0]              pend_idx_r;
    logic                             word_pend_r;
    logic                             seen_rise_r;

    logic sck_rise_s, sck_fall_s, ss_fall_s, ss_rise_s;
    logic start_s, finish_s, rise_act_s, fall_act_s;
    logic [WORD_BITS-1:0] boundary_word_s;

    // Two-flop synchronisers and the edge-detect copy; armed_r only goes high
    // once a genuine (post-reset) high level of ss_n has been seen, so a select
    // held low through reset release cannot start a frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_meta_r  <= 1'b0;
            sck_sync_r  <= 1'b0;
            sck_prev_r  <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            ss_meta_r   <= 1'b1;
            ss_sync_r   <= 1'b1;
            ss_prev_r   <= 1'b1;
            sync_fill_r <= 2'd0;
            armed_r     <= 1'b0;
        end else begin
            sck_meta_r  <= sck;
            sck_sync_r  <= sck_meta_r;
            sck_prev_r  <= sck_sync_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
            ss_meta_r   <= ss_n;
            ss_sync_r   <= ss_meta_r;
            ss_prev_r   <= ss_sync_r;
            sync_fill_r <= (sync_fill_r == 2'd2) ? 2'd2 : sync_fill_r + 2'd1;
            armed_r     <= armed_r | ((sync_fill_r == 2'd2) & ss_sync_r);
        end
    end

    // Edge detection on the synchronised pins.
    always_comb begin
        sck_rise_s = sck_sync_r & ~sck_prev_r;
        sck_fall_s = ~sck_sync_r & sck_prev_r;
        ss_fall_s  = ~ss_sync_r & ss_prev_r & armed_r;
        ss_rise_s  = ss_sync_r & ~ss_prev_r;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and per-cycle action decode. A slave-select rise takes
    // priority over any sck edge seen in the same cycle.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        finish_s     = 1'b0;
        rise_act_s   = 1'b0;
        fall_act_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    next_state_s = ST_ACTIVE;
                    start_s      = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    if (word_pend_r) begin
                        next_state_s = ST_CLOSING;
                    end else begin
                        next_state_s = ST_IDLE;
                        finish_s     = 1'b1;
                    end
                end else begin
                    next_state_s = ST_ACTIVE;
                    rise_act_s   = sck_rise_s;
                    // A fall before the first rise would skip word 0's MSB.
                    fall_act_s   = sck_fall_s & seen_rise_r;
                end
            end
            ST_CLOSING: begin
                next_state_s = ST_IDLE;
                finish_s     = 1'b1;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Word loaded at a word boundary: shadow word word_idx, or zeros once the
    // nominal frame length has been exceeded.
    always_comb begin
        if (word_idx_r < FULL_IDX) begin
            boundary_word_s = shadow_word(shadow_r, word_idx_r);
        end else begin
            boundary_word_s = {WORD_BITS{1'b0}};
        end
    end

    // Frame datapath: shift registers, counters and all registered outputs.
    // word_idx_r advances on the last-bit rise so that the following fall
    // loads the next response word and frame_done sees the final count even
    // when the strobe for the last word is still pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_r       <= '0;
            tx_shift_r     <= '0;
            rx_shift_r     <= '0;
            bit_cnt_r      <= '0;
            word_idx_r     <= '0;
            pend_idx_r     <= '0;
            word_pend_r    <= 1'b0;
            seen_rise_r    <= 1'b0;
            miso           <= 1'b0;
            miso_en        <= 1'b0;
            rx_word        <= '0;
            rx_word_valid  <= 1'b0;
            rx_word_index  <= '0;
            frame_active   <= 1'b0;
            frame_done     <= 1'b0;
            frame_error    <= 1'b0;
            words_received <= '0;
        end else begin
            rx_word_valid <= 1'b0;
            frame_done    <= 1'b0;

            if (word_pend_r) begin
                rx_word       <= rx_shift_r;
                rx_word_valid <= 1'b1;
                rx_word_index <= pend_idx_r;
                word_pend_r   <= 1'b0;
            end

            if (start_s) begin
                shadow_r     <= tx_data;
                tx_shift_r   <= tx_data[WORD_BITS-1:0];
                miso         <= tx_data[WORD_BITS-1];
                miso_en      <= 1'b1;
                rx_shift_r   <= '0;
                bit_cnt_r    <= '0;
                word_idx_r   <= '0;
                seen_rise_r  <= 1'b0;
                frame_active <= 1'b1;
            end

            if (rise_act_s) begin
                rx_shift_r  <= {rx_shift_r[WORD_BITS-2:0], mosi_sync_r};
                seen_rise_r <= 1'b1;
                if (bit_cnt_r == LAST_BIT) begin
                    bit_cnt_r   <= '0;
                    word_pend_r <= 1'b1;
                    pend_idx_r  <= (word_idx_r >= FULL_IDX) ? FULL_IDX : word_idx_r;
                    word_idx_r  <= (word_idx_r >= SAT_IDX) ? SAT_IDX
                                                           : word_idx_r + IDX_BITS'(1);
                end else begin
                    bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                end
            end

            if (fall_act_s) begin
                if (bit_cnt_r != '0) begin
                    tx_shift_r <= {tx_shift_r[WORD_BITS-2:0], 1'b0};
                    miso       <= tx_shift_r[WORD_BITS-2];
                end else begin
                    tx_shift_r <= boundary_word_s;
                    miso       <= boundary_word_s[WORD_BITS-1];
                end
            end

            if (finish_s) begin
                frame_done     <= 1'b1;
                miso           <= 1'b0;
                miso_en        <= 1'b0;
                frame_active   <= 1'b0;
                words_received <= word_idx_r;
                frame_error    <= (bit_cnt_r != '0) || (word_idx_r != FULL_IDX);
            end
        end
    end

endmodule

// File: doc/myo_spi_responder.md
Name: myo_spi_responder

Overview:
- SPI slave that acts as the far end of the myocontrol SPI master link. It lets the fabric emulate a motor board, for loop-back testing of the myocontrol master without hardware.
- The SPI pins are asynchronous. They are oversampled in the system clock domain.
- Each frame is FRAME_WORDS words, MSB first, SPI mode 0.
- Each received word is reported on a parallel strobe interface. Response words come from a parallel TX vector, captured at frame start.

Parameters:
- WORD_BITS, 16, bits per SPI word
- FRAME_WORDS, 4, words per nominal frame
- IDX_BITS, 3, width of word index/counters; must hold FRAME_WORDS+1

Ports:
- clock  in  1  system clock; must be at least 8x SCK frequency
- reset  in  1  synchronous, active-high reset
- sck  in  1  SPI clock from master, asynchronous
- mosi  in  1  SPI data from master, asynchronous
- ss_n  in  1  slave select, active low, asynchronous
- miso  out  1  SPI data to master
- miso_en  out  1  high while selected (drives top-level tristate)
- tx_data  in  WORD_BITS*FRAME_WORDS  response words; word k = bits [(k+1)*WORD_BITS-1 : k*WORD_BITS]
- rx_word  out  WORD_BITS  last completed received word
- rx_word_valid  out  1  one-cycle strobe, rx_word/rx_word_index valid
- rx_word_index  out  IDX_BITS  position of rx_word in frame (0-based)
- frame_active  out  1  high in ACTIVE state
- frame_done  out  1  one-cycle strobe at frame end
- frame_error  out  1  valid with frame_done; held until next frame_done
- words_received  out  IDX_BITS  complete words in last frame, saturating at FRAME_WORDS+1

Behaviour:
- Input synchronisation:
  - sck, mosi and ss_n each pass through 2 flops.
  - The synchroniser flops reset to sck=0, mosi=0, ss_n=1.
  - Edges are detected against a third registered copy. Pin edge to internal action is 3 clocks.
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts the frame silently (no frame_done).
  - A new frame needs a synced ss_n falling edge.
  - If ss_n is held low through reset release, nothing starts.
- IDLE:
  - miso=0, miso_en=0; sck edges are ignored.
  - On ss_n fall: tx_data is captured into a shadow register and the TX shift register is loaded with word 0.
  - Also on ss_n fall: miso = word0 MSB, miso_en=1, bit_cnt=0, word_idx=0, then go to ACTIVE.
- ACTIVE, sck rising:
  - rx_shift = {rx_shift[WORD_BITS-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt was WORD_BITS-1: bit_cnt=0, and on the next cycle rx_word = assembled word, rx_word_valid=1, rx_word_index=word_idx.
  - Then word_idx++, saturating at FRAME_WORDS+1.
- ACTIVE, sck falling:
  - If bit_cnt!=0: shift TX, miso = next bit.
  - If bit_cnt==0 (word boundary): load shadow word word_idx, miso = its MSB.
  - If word_idx>=FRAME_WORDS: load zeros.
  - A falling edge before the first rising edge of a frame is ignored, so the MSB of word0 is not skipped.
- ACTIVE, ss_n rising:
  - Next cycle: frame_done=1 for 1 cycle, state IDLE, miso=0, miso_en=0.
  - words_received = word_idx.
  - frame_error = (bit_cnt!=0) OR (word_idx!=FRAME_WORDS).
  - A partial word is discarded (no rx_word_valid).
- Simultaneous events:
  - ss_n rise and an sck edge in the same synced cycle: ss_n wins, the sck edge is ignored.
  - A last-bit sck rise followed by an ss_n rise 1 clock later still produces rx_word_valid, before frame_done.
- Overrun: words beyond FRAME_WORDS are still strobed, with rx_word_index saturated at FRAME_WORDS. frame_error is set.
- rx_word holds its value between strobes. tx_data changes during a frame have no effect.

Test Plan:
- Nominal frame:
  - Stimulus: tx_data words 0..3 = 0xA5A5, 0x1234, 0x0000, 0xFFFF. Master sends 0x8001, 0x0002, 0x0003, 0xBEEF at clock/16.
  - Required: 4 rx_word_valid strobes with index 0..3 and those values. Master reads back the tx words. frame_done with frame_error=0, words_received=4.
- Short frame: ss_n rises after 20 bits.
  - Required: 1 strobe (index 0). frame_done with frame_error=1, words_received=1.
- Long frame: 5 words.
  - Required: 5 strobes, the 5th with index 4. miso=0 throughout word 4. frame_error=1, words_received=5.
- Reset mid-frame: assert reset after 9 bits of word 1.
  - Required: all outputs 0, no frame_done.
  - With ss_n still low after reset, sck toggling produces no strobes.
  - A subsequent clean frame passes as in the nominal case.
- tx_data stability: change tx_data to all-ones after ss_n falls.
  - Required: miso still returns the values captured at frame start. The next frame returns 0xFFFF x4.
- Timing corner: ss_n rises 3 system clocks after the last sck rise of word 3.
  - Required: rx_word_valid for index 3 precedes frame_done; frame_error=0.
